sigma_serial: RTL and testbench
===============================

SIGMA_SERIAL -- requirements
Module: sigma_serial

Interface
REQ-001 Parameter: w_word, default 32, word width in bits; only 32 is supported for the SHA-256 functions.
REQ-002 Port: clk  input  1  system clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: bclk  input  1  bit clock, sampled in the clk domain; never used as a clock.
REQ-005 Port: counter  input  $clog2(w_word)  bit index of the current bit in the frame, 0 = LSB.
REQ-006 Port: mode  input  2  function select: 0 = Sigma0, 1 = Sigma1, 2 = sigma0, 3 = sigma1.
REQ-007 Port: in  input  1  serial input word bit, LSB first.
REQ-008 Port: out  output  1  serial result bit, LSB first, valid from a bclk falling edge until the next one.
REQ-009 Port: out_valid  output  1  high while out carries a result bit of a completed frame.

Function
REQ-010 The block SHALL register bclk into bclk_prev every clk cycle.
REQ-011 Rising event = !bclk_prev && bclk, used for record; falling event = bclk_prev && !bclk, used for play.
REQ-012 On a rising event, cap[counter] <= in (capture register, w_word bits).
REQ-013 On a rising event with counter == 0, mode SHALL be latched into mode_cap; mode changes elsewhere in the frame are ignored.
REQ-014 On a rising event with counter == w_word-1, the block SHALL:
  - compute res from {in, cap[w_word-2:0]} and mode_cap;
  - load res into the play register;
  - set frame_ok.
REQ-015 Functions (ROTR = rotate right, SHR = logical shift right):
  - Sigma0 = ROTR2 ^ ROTR13 ^ ROTR22
  - Sigma1 = ROTR6 ^ ROTR11 ^ ROTR25
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10
REQ-016 On a falling event, out <= play[counter] and out_valid <= frame_ok.
REQ-017 Latency is exactly one frame: the word recorded in frame N is played in frame N+1 at the same bit indices.
REQ-018 Recording frame N+1 and playing frame N SHALL overlap without corruption; cap and play are separate registers.
REQ-019 A new word loads play only at counter == w_word-1, after the play of bit w_word-1 of the previous frame.
REQ-020 If rising and falling events cannot coincide (single bclk_prev), no arbitration is needed; both SHALL be evaluated in the same always block.
REQ-021 Between events, out, out_valid, cap and play SHALL hold their values.
REQ-022 A counter jump (not sequential) SHALL be honoured as given: bits are indexed by counter, not by an internal count.
REQ-023 If bclk stops, all state holds indefinitely.

Reset
REQ-024 While rst is high, the block SHALL clear:
  - out = 0, out_valid = 0, frame_ok = 0;
  - cap = 0, play = 0, mode_cap = 0.
REQ-025 While rst is high, bclk_prev <= bclk, so no spurious edge is detected in the first cycle after reset.
REQ-026 Reset mid-frame SHALL discard the partial word.
REQ-027 After a mid-frame reset, out_valid stays 0 until a full frame completes, meaning a rising event at counter == w_word-1.
REQ-028 A frame begun after reset but entered mid-frame (first counter != 0) SHALL still complete and load play; mode_cap then holds its reset value 0 unless counter 0 was seen.

Verification
REQ-029 mode=2, word 0x00000001 in frame 0 -> frame 1 out bits form 0x02004000, out_valid=1 on every falling event.
REQ-030 mode=0, word 0x00000001 -> next frame plays 0x40080400.
REQ-031 mode=3, word 0x80000000, then mode=1, word 0xFFFFFFFF back to back -> plays 0x00205000, then 0xFFFFFFFF.
REQ-032 mode=2, word 0xFFFFFFFF, with mode toggled to 0 at counter 5 -> plays 0x1FFFFFFF (mid-frame mode ignored).
REQ-033 rst pulsed at counter 15 of a frame -> out=0, out_valid=0.
  - The next frame plays nothing valid.
  - Results resume one full frame after the next complete word.
REQ-034 bclk held high through rst release -> no cap write or out change until the next genuine rising event.

Source files
------------

// File: rtl/sigma_serial.sv
// sigma_serial: bit-serial SHA-256 Sigma/sigma function unit.
// A word is recorded LSB first on bclk rising events and its selected function result
// is played back LSB first on bclk falling events during the following frame.
// bclk is only sampled in the clk domain; every register below runs on clk.
module sigma_serial #(
    // Only 32 is meaningful for the SHA-256 rotate/shift amounts used below.
    parameter int unsigned w_word = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bclk,
    input  logic [$clog2(w_word)-1:0] counter,
    input  logic [1:0]                mode,
    input  logic                      in,
    output logic                      out,
    output logic                      out_valid
);

    localparam int unsigned cw = $clog2(w_word);
    localparam logic [cw-1:0] first_idx = '0;
    localparam logic [cw-1:0] last_idx = cw'(w_word - 1);

    typedef enum logic [1:0] {
        ModeBigSigma0   = 2'd0,
        ModeBigSigma1   = 2'd1,
        ModeSmallSigma0 = 2'd2,
        ModeSmallSigma1 = 2'd3
    } mode_e;

    logic              bclk_prev;
    logic              rise;
    logic              fall;
    logic [w_word-1:0] cap;
    logic [w_word-1:0] cap_next;
    logic [w_word-1:0] play;
    logic [w_word-1:0] res;
    mode_e             mode_cap;
    logic              frame_ok;

    function automatic logic [w_word-1:0] rotr(input logic [w_word-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (w_word - n));
    endfunction

    function automatic logic [w_word-1:0] shr(input logic [w_word-1:0] x,
                                              input int unsigned n);
        return x >> n;
    endfunction

    // Edge events of the sampled bit clock; they can never be true together.
    assign rise = !bclk_prev && bclk;
    assign fall = bclk_prev && !bclk;

    // Capture word as it will look after this cycle's bit is written; at the last
    // index this is {in, cap[w_word-2:0]}, so the result needs no extra cycle.
    always_comb begin
        cap_next          = cap;
        cap_next[counter] = in;
    end

    // Function selected by the mode latched at bit 0 of the frame.
    always_comb begin
        res = '0;
        unique case (mode_cap)
            ModeBigSigma0:   res = rotr(cap_next, 2)  ^ rotr(cap_next, 13) ^ rotr(cap_next, 22);
            ModeBigSigma1:   res = rotr(cap_next, 6)  ^ rotr(cap_next, 11) ^ rotr(cap_next, 25);
            ModeSmallSigma0: res = rotr(cap_next, 7)  ^ rotr(cap_next, 18) ^ shr(cap_next, 3);
            ModeSmallSigma1: res = rotr(cap_next, 17) ^ rotr(cap_next, 19) ^ shr(cap_next, 10);
            default:         res = '0;
        endcase
    end

    // Record on rising events, play on falling events; everything else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Track bclk during reset so a high bclk at release is not seen as an edge.
            bclk_prev <= bclk;
            cap       <= '0;
            play      <= '0;
            mode_cap  <= ModeBigSigma0;
            frame_ok  <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            bclk_prev <= bclk;
            if (rise) begin
                cap <= cap_next;
                if (counter == first_idx) begin
                    mode_cap <= mode_e'(mode);
                end
                // Bit w_word-1 is played before it is recorded, so reloading play
                // here never disturbs the frame currently being played.
                if (counter == last_idx) begin
                    play     <= res;
                    frame_ok <= 1'b1;
                end
            end
            if (fall) begin
                out       <= play[counter];
                out_valid <= frame_ok;
            end
        end
    end

endmodule

// File: tb/tb_sigma_serial.sv
// Self-checking bench for sigma_serial: directed SHA-256 vectors, resets, mid-frame
// entry, counter jumps and randomized frames against a bit-level reference model.
module tb_sigma_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       bclk;
    logic [4:0] counter;
    logic [1:0] mode;
    logic       in;
    logic       out;
    logic       out_valid;

    int total;
    int bad;

    // Reference model state: what the block should be playing and what it has recorded.
    logic [31:0] exp_play;
    logic        exp_valid;
    logic [31:0] cap_word;
    logic [1:0]  model_mode;

    sigma_serial #(.w_word(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bclk      (bclk),
        .counter   (counter),
        .mode      (mode),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Result bit i of ROTRn is source bit (i+n) mod 32.
    function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
        return r;
    endfunction

    // Result bit i of SHRn is source bit i+n, zero past the top.
    function automatic logic [31:0] ref_shr(input logic [31:0] x, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? x[i + n] : 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] ref_fn(input logic [31:0] x, input logic [1:0] m);
        case (m)
            2'd0:    return ref_rotr(x, 2)  ^ ref_rotr(x, 13) ^ ref_rotr(x, 22);
            2'd1:    return ref_rotr(x, 6)  ^ ref_rotr(x, 11) ^ ref_rotr(x, 25);
            2'd2:    return ref_rotr(x, 7)  ^ ref_rotr(x, 18) ^ ref_shr(x, 3);
            default: return ref_rotr(x, 17) ^ ref_rotr(x, 19) ^ ref_shr(x, 10);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bit period: falling event (play) then rising event (record).
    task automatic drive_bit(input logic [4:0] idx, input logic b, input logic [1:0] m,
                             output logic o, output logic ov);
        @(negedge clk);
        counter = idx;
        in      = b;
        mode    = m;
        bclk    = 1'b0;
        repeat (2) @(negedge clk);
        o  = out;
        ov = out_valid;
        bclk = 1'b1;
        repeat (2) @(negedge clk);
        // Model the recording side of this bit period.
        cap_word[idx] = b;
        if (idx == 5'd0) model_mode = m;
        if (idx == 5'd31) begin
            exp_play  = ref_fn(cap_word, model_mode);
            exp_valid = 1'b1;
        end
    endtask

    // A frame visiting indices start..30 (optionally shuffled) then 31; mode switches
    // from m to m2 at step flip_at. Checks the played bits against the previous result.
    task automatic run_frame(input string tag, input logic [31:0] word, input logic [1:0] m,
                             input int flip_at, input logic [1:0] m2, input int start,
                             input bit shuffle, output logic [31:0] got);
        int          ord[$];
        logic [31:0] gv;
        logic [31:0] mask;
        logic [31:0] old_play;
        logic        old_valid;
        logic        o;
        logic        ov;
        got       = '0;
        gv        = '0;
        mask      = '0;
        old_play  = exp_play;
        old_valid = exp_valid;
        for (int i = start; i < 31; i++) ord.push_back(i);
        if (shuffle) begin
            for (int i = ord.size() - 1; i > 0; i--) begin
                int j;
                int t;
                j      = int'($urandom_range(0, i));
                t      = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
        end
        ord.push_back(31);
        for (int k = 0; k < ord.size(); k++) begin
            logic [4:0] idx;
            idx = 5'(ord[k]);
            drive_bit(idx, word[idx], (k >= flip_at) ? m2 : m, o, ov);
            got[idx]  = o;
            gv[idx]   = ov;
            mask[idx] = 1'b1;
        end
        got = got & mask;
        check({tag, "_data"}, got, old_play & mask);
        check({tag, "_valid"}, gv & mask, old_valid ? mask : 32'h0);
    endtask

    // Reset with bclk held high; a genuine bit-31 rising event would load play.
    task automatic do_reset(input string tag, input logic [4:0] idx);
        @(negedge clk);
        rst     = 1'b1;
        bclk    = 1'b1;
        counter = idx;
        in      = 1'b1;
        mode    = 2'd3;
        repeat (3) @(negedge clk);
        check({tag, "_in_rst"}, {30'b0, out_valid, out}, 32'h0);
        rst     = 1'b0;
        counter = 5'd31;
        repeat (4) @(negedge clk);
        check({tag, "_after_rst"}, {30'b0, out_valid, out}, 32'h0);
        exp_play   = '0;
        exp_valid  = 1'b0;
        cap_word   = '0;
        model_mode = 2'd0;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] w;
        logic        o;
        logic        ov;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bclk       = 1'b1;
        counter    = 5'd31;
        in         = 1'b1;
        mode       = 2'd0;
        exp_play   = '0;
        exp_valid  = 1'b0;
        cap_word   = '0;
        model_mode = 2'd0;

        do_reset("init", 5'd31);

        // Directed vectors; the first frame after reset plays nothing valid.
        run_frame("f0", 32'h00000001, 2'd2, 99, 2'd2, 0, 1'b0, got);
        run_frame("f1", 32'h00000001, 2'd0, 99, 2'd0, 0, 1'b0, got);
        check("s0_of_1", got, 32'h02004000);
        run_frame("f2", 32'h80000000, 2'd3, 99, 2'd3, 0, 1'b0, got);
        check("S0_of_1", got, 32'h40080400);
        run_frame("f3", 32'hFFFFFFFF, 2'd1, 99, 2'd1, 0, 1'b0, got);
        check("s1_of_msb", got, 32'h00205000);
        run_frame("f4", 32'hFFFFFFFF, 2'd2, 5, 2'd0, 0, 1'b0, got);
        check("S1_of_ones", got, 32'hFFFFFFFF);
        run_frame("f5", $urandom, 2'(int'($urandom_range(0, 3))), 99, 2'd0, 0, 1'b0, got);
        check("s0_mode_flip", got, 32'h1FFFFFFF);

        // Randomized frames: random words, modes, mid-frame mode changes, counter jumps.
        for (int n = 0; n < 10; n++) begin
            run_frame($sformatf("rnd%0d", n), $urandom, 2'(int'($urandom_range(0, 3))),
                      int'($urandom_range(1, 40)), 2'(int'($urandom_range(0, 3))), 0,
                      n[0], got);
        end

        // Reset at bit 15 of a frame: partial word discarded, next frame invalid.
        w = $urandom;
        for (int i = 0; i < 15; i++) drive_bit(5'(i), w[i], 2'd1, o, ov);
        do_reset("mid", 5'd15);
        run_frame("post_mid0", $urandom, 2'd3, 99, 2'd3, 0, 1'b0, got);
        run_frame("post_mid1", $urandom, 2'd2, 99, 2'd2, 0, 1'b0, got);
        run_frame("post_mid2", $urandom, 2'd1, 99, 2'd1, 0, 1'b1, got);

        // Frame entered at bit 10 after reset: completes with mode 0 and zero low bits.
        do_reset("late", 5'd31);
        run_frame("late0", $urandom, 2'd3, 99, 2'd3, 10, 1'b0, got);
        run_frame("late1", $urandom, 2'd2, 99, 2'd2, 0, 1'b0, got);
        run_frame("late2", $urandom, 2'd0, 99, 2'd0, 0, 1'b0, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
